raster_scheduler: RTL and testbench

Sequences the single-cycle `pixel_calculator` stage across every pixel of each incoming screen-space triangle. It clears the framebuffer at frame start, then accepts triangles one at a time and computes a screen-clipped bounding box. For each pixel in the box it issues a framebuffer read, feeds the read data and coordinates to the calculator, and writes the calculator's result back. It sits between the triangle projection stage (upstream) and the dual-port framebuffer BRAM (downstream).

---
 rtl/raster_scheduler_if.sv | 46 ++++
 rtl/raster_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_raster_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_scheduler_if.sv
// Triangle intake, framebuffer ports and pixel_calculator link
// of the raster scheduler; master is the scheduler side.
interface raster_scheduler_if;
    logic         frame_start;
    logic         tri_valid;
    logic         tri_ready;
    logic [127:0] tri_data;
    logic         tri_last;
    logic         fb_rd_en;
    logic [15:0]  fb_rd_addr;
    logic [31:0]  fb_rd_data;
    logic         fb_wr_en;
    logic [15:0]  fb_wr_addr;
    logic [31:0]  fb_wr_data;
    logic         pc_valid;
    logic [8:0]   pc_xcoord;
    logic [7:0]   pc_ycoord;
    logic [31:0]  pc_pixel_data;
    logic [127:0] pc_triangle;
    logic         pc_valid_in;
    logic [8:0]   pc_xcoord_in;
    logic [7:0]   pc_ycoord_in;
    logic [31:0]  pc_pixel_data_in;
    logic         busy;
    logic         frame_done;

    modport master (
        input  frame_start, tri_valid, tri_data, tri_last,
        input  fb_rd_data,
        input  pc_valid_in, pc_xcoord_in, pc_ycoord_in, pc_pixel_data_in,
        output tri_ready, fb_rd_en, fb_rd_addr,
        output fb_wr_en, fb_wr_addr, fb_wr_data,
        output pc_valid, pc_xcoord, pc_ycoord, pc_pixel_data, pc_triangle,
        output busy, frame_done
    );

    modport slave (
        output frame_start, tri_valid, tri_data, tri_last,
        output fb_rd_data,
        output pc_valid_in, pc_xcoord_in, pc_ycoord_in, pc_pixel_data_in,
        input  tri_ready, fb_rd_en, fb_rd_addr,
        input  fb_wr_en, fb_wr_addr, fb_wr_data,
        input  pc_valid, pc_xcoord, pc_ycoord, pc_pixel_data, pc_triangle,
        input  busy, frame_done
    );
endinterface

// File: rtl/raster_scheduler.sv
// Clears the framebuffer, then walks each triangle's screen-clipped
// bounding box through pixel_calculator as read/modify/write.
module raster_scheduler #(
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 180,
    parameter int READ_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    raster_scheduler_if.master bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic signed [15:0] XLAST = 16'(WIDTH - 1);
    localparam logic signed [15:0] YLAST = 16'(HEIGHT - 1);
    localparam logic [15:0] CLR_END = 16'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, WAIT_TRI, SETUP, SCAN, DRAIN, DONE
    } state_e;

    state_e              state_q;
    logic [127:0]        tri_q;
    logic                last_q;
    logic [15:0]         clr_q;
    logic [15:0]         addr_q;
    logic [15:0]         row_q;
    logic [8:0]          x_q;
    logic [8:0]          xmin_q;
    logic [8:0]          xmax_q;
    logic [7:0]          y_q;
    logic [7:0]          ymax_q;
    logic [READ_LAT-1:0] sv_q;
    logic [8:0]          sx_q [READ_LAT];
    logic [7:0]          sy_q [READ_LAT];
    logic                wr_ok_q;

    function automatic logic signed [15:0] min3(
        input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(
        input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [15:0] clamp(
        input logic signed [15:0] v,
        input logic signed [15:0] hi);
        if (v[15]) return 16'd0;
        if (v > hi) return hi;
        return v;
    endfunction

    logic signed [15:0] xlo_d, xhi_d, ylo_d, yhi_d;
    logic               off_d;
    logic [8:0]         xmin_d, xmax_d;
    logic [7:0]         ymin_d, ymax_d;
    logic [15:0]        start_d;

    always_comb begin
        xlo_d   = min3(tri_q[111:96], tri_q[79:64], tri_q[47:32]);
        xhi_d   = max3(tri_q[111:96], tri_q[79:64], tri_q[47:32]);
        ylo_d   = min3(tri_q[95:80], tri_q[63:48], tri_q[31:16]);
        yhi_d   = max3(tri_q[95:80], tri_q[63:48], tri_q[31:16]);
        off_d   = xhi_d[15] || yhi_d[15] || (xlo_d > XLAST) || (ylo_d > YLAST);
        xmin_d  = 9'(clamp(xlo_d, XLAST));
        xmax_d  = 9'(clamp(xhi_d, XLAST));
        ymin_d  = 8'(clamp(ylo_d, YLAST));
        ymax_d  = 8'(clamp(yhi_d, YLAST));
        start_d = 16'(32'(ymin_d) * WIDTH + 32'(xmin_d));
    end

    // Stale calculator results are dropped unless we fed it a pixel last cycle.
    always_comb begin
        bus.fb_wr_en   = 1'b0;
        bus.fb_wr_addr = 16'd0;
        bus.fb_wr_data = 32'd0;
        if (state_q == CLEAR) begin
            bus.fb_wr_en   = 1'b1;
            bus.fb_wr_addr = clr_q;
            bus.fb_wr_data = 32'h0000_FFFF;
        end else if (bus.pc_valid_in && wr_ok_q) begin
            bus.fb_wr_en   = 1'b1;
            bus.fb_wr_addr = 16'(32'(bus.pc_ycoord_in) * WIDTH
                                 + 32'(bus.pc_xcoord_in));
            bus.fb_wr_data = bus.pc_pixel_data_in;
        end
    end

    assign bus.tri_ready     = (state_q == WAIT_TRI);
    assign bus.fb_rd_en      = (state_q == SCAN);
    assign bus.fb_rd_addr    = addr_q;
    assign bus.pc_valid      = sv_q[READ_LAT-1];
    assign bus.pc_xcoord     = sx_q[READ_LAT-1];
    assign bus.pc_ycoord     = sy_q[READ_LAT-1];
    assign bus.pc_pixel_data = sv_q[READ_LAT-1] ? bus.fb_rd_data : 32'd0;
    assign bus.pc_triangle   = tri_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.frame_done    = (state_q == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tri_q   <= '0;
            last_q  <= 1'b0;
            clr_q   <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            x_q     <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            y_q     <= '0;
            ymax_q  <= '0;
            sv_q    <= '0;
            wr_ok_q <= 1'b0;
            for (int k = 0; k < READ_LAT; k++) begin
                sx_q[k] <= '0;
                sy_q[k] <= '0;
            end
        end else begin
            for (int k = READ_LAT - 1; k > 0; k--) begin
                sv_q[k] <= sv_q[k-1];
                sx_q[k] <= sx_q[k-1];
                sy_q[k] <= sy_q[k-1];
            end
            sv_q[0] <= (state_q == SCAN);
            sx_q[0] <= x_q;
            sy_q[0] <= y_q;
            wr_ok_q <= sv_q[READ_LAT-1];

            unique case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        clr_q   <= '0;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_q <= clr_q + 16'd1;
                    if (clr_q == CLR_END) begin
                        clr_q   <= '0;
                        state_q <= WAIT_TRI;
                    end
                end
                WAIT_TRI: begin
                    if (bus.tri_valid) begin
                        tri_q   <= bus.tri_data;
                        last_q  <= bus.tri_last;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (off_d) begin
                        state_q <= last_q ? DONE : WAIT_TRI;
                    end else begin
                        x_q     <= xmin_d;
                        xmin_q  <= xmin_d;
                        xmax_q  <= xmax_d;
                        y_q     <= ymin_d;
                        ymax_q  <= ymax_d;
                        addr_q  <= start_d;
                        row_q   <= start_d;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (x_q != xmax_q) begin
                        x_q    <= x_q + 9'd1;
                        addr_q <= addr_q + 16'd1;
                    end else if (y_q != ymax_q) begin
                        x_q    <= xmin_q;
                        y_q    <= y_q + 8'd1;
                        row_q  <= row_q + 16'(WIDTH);
                        addr_q <= row_q + 16'(WIDTH);
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty pipe before the next read avoids overlap RAW hazards.
                    if (sv_q == '0 && !bus.pc_valid_in)
                        state_q <= last_q ? DONE : WAIT_TRI;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: framebuffer and z-test calculator models,
// table vectors, randomized frames against a box-walk reference.
module tb_raster_scheduler;
  localparam int W = 64;
  localparam int H = 36;
  localparam int RL = 2;
  localparam int NPIX = W * H;
  localparam int TMO = 8000;
  localparam int OVA = 5 * W + 5;

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    int depth, color;
    int n, first, done_off;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  raster_scheduler_if bus();

  raster_scheduler #(
    .WIDTH(W), .HEIGHT(H), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] zfun(input logic [31:0] old,
                                       input logic [127:0] t);
    return (t[15:0] < old[15:0]) ? {t[127:112], t[15:0]} : old;
  endfunction

  logic [31:0] fb [NPIX];
  logic [31:0] rdp [RL];
  int wa, ra;
  always @(posedge clk) begin
    wa = int'(bus.fb_wr_addr);
    ra = int'(bus.fb_rd_addr);
    if (bus.fb_wr_en && wa < NPIX) fb[wa] <= bus.fb_wr_data;
    rdp[0] <= (bus.fb_rd_en && ra < NPIX) ? fb[ra] : 32'd0;
    for (int k = 1; k < RL; k++) rdp[k] <= rdp[k-1];
  end
  assign bus.fb_rd_data = rdp[RL-1];

  always @(posedge clk) begin
    bus.pc_valid_in      <= bus.pc_valid;
    bus.pc_xcoord_in     <= bus.pc_xcoord;
    bus.pc_ycoord_in     <= bus.pc_ycoord;
    bus.pc_pixel_data_in <= zfun(bus.pc_pixel_data, bus.pc_triangle);
  end

  int exp_rd[$];
  logic [31:0] ref_fb [NPIX];
  int rd_cnt, rd_bad, wr_cnt, wr_oob, rd_first, rd_last_cyc;
  int rdova, rdova2_cyc, wrova_cyc, qf;

  always @(negedge clk) begin
    if (bus.fb_rd_en) begin
      if (rd_cnt == 0) rd_first = int'(bus.fb_rd_addr);
      rd_cnt++;
      rd_last_cyc = cyc;
      if (exp_rd.size() == 0) rd_bad++;
      else begin
        qf = exp_rd.pop_front();
        if (qf != int'(bus.fb_rd_addr)) rd_bad++;
      end
      if (int'(bus.fb_rd_addr) == OVA) begin
        rdova++;
        if (rdova == 2) rdova2_cyc = cyc;
      end
    end
    if (bus.fb_wr_en) begin
      wr_cnt++;
      if (int'(bus.fb_wr_addr) >= NPIX) wr_oob++;
      if (int'(bus.fb_wr_addr) == OVA && wrova_cyc < 0) wrova_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic reset_counts();
    rd_cnt = 0; rd_bad = 0; wr_cnt = 0; wr_oob = 0;
    rdova = 0; rdova2_cyc = -1; wrova_cyc = -1;
    exp_rd.delete();
  endtask

  function automatic logic [127:0] mk(input int c, x1, y1, x2, y2,
                                      x3, y3, d);
    return {16'(c), 16'(x1), 16'(y1), 16'(x2), 16'(y2),
            16'(x3), 16'(y3), 16'(d)};
  endfunction

  // Reference: clip the box, visit pixels in raster order, z-test each.
  task automatic ref_tri(input int x1, y1, x2, y2, x3, y3,
                         input logic [127:0] t, output int n);
    int xl, xh, yl, yh, a;
    xl = (x1 < x2) ? x1 : x2; xl = (x3 < xl) ? x3 : xl;
    xh = (x1 > x2) ? x1 : x2; xh = (x3 > xh) ? x3 : xh;
    yl = (y1 < y2) ? y1 : y2; yl = (y3 < yl) ? y3 : yl;
    yh = (y1 > y2) ? y1 : y2; yh = (y3 > yh) ? y3 : yh;
    n = 0;
    if (xh < 0 || yh < 0 || xl > W - 1 || yl > H - 1) return;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        a = y * W + x;
        exp_rd.push_back(a);
        ref_fb[a] = zfun(ref_fb[a], t);
        n++;
      end
  endtask

  task automatic start_frame();
    int bad = 0;
    @(negedge clk); bus.frame_start = 1'b1;
    @(negedge clk); bus.frame_start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      if (!(bus.fb_wr_en && int'(bus.fb_wr_addr) == i &&
            bus.fb_wr_data == 32'h0000_FFFF && !bus.fb_rd_en &&
            bus.busy && !bus.tri_ready)) bad++;
      @(negedge clk);
    end
    chk("clear_seq", bad, 0);
    chk("clear_then_ready", bus.tri_ready, 1);
    for (int i = 0; i < NPIX; i++) ref_fb[i] = 32'h0000_FFFF;
    reset_counts();
  endtask

  task automatic send_tri(input logic [127:0] t, input bit last,
                          input int gap, output int hs);
    int n = 0;
    repeat (gap) @(negedge clk);
    bus.tri_valid = 1'b1; bus.tri_data = t; bus.tri_last = last;
    while (!bus.tri_ready && n < TMO) begin @(negedge clk); n++; end
    chk("tri_ready_seen", n < TMO, 1);
    hs = cyc;
    @(negedge clk);
    bus.tri_valid = 1'b0; bus.tri_last = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!bus.frame_done && n < TMO) begin @(negedge clk); n++; end
    chk("done_seen", n < TMO, 1);
    dc = cyc;
    @(negedge clk);
    chk("done_one_cycle", bus.frame_done, 0);
    chk("idle_after_done", bus.busy, 0);
  endtask

  task automatic chk_fb(input string nm);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) if (fb[i] !== ref_fb[i]) bad++;
    chk(nm, bad, 0);
  endtask

  vec_t tv[8];
  logic [127:0] t, tb2;
  int hs, hs2, dc, n, tot, ntri;
  int c[6];

  initial begin
    tv[0] = '{10, 10, 13, 10, 10, 13, 100, 'hF800, 16, 650, 22};
    tv[1] = '{-50, -20, 400, -20, 100, 300, 500, 'h001F, NPIX, 0, NPIX + 6};
    tv[2] = '{-5, 3, -1, 4, -9, 8, 10, 'h1234, 0, 0, 2};
    tv[3] = '{63, 35, 63, 35, 63, 35, 7, 'hABCD, 1, NPIX - 1, 7};
    tv[4] = '{1, 36, 5, 40, 2, 50, 10, 'h4321, 0, 0, 2};
    tv[5] = '{0, 0, 63, 0, 30, 0, 65534, 'h0F0F, 64, 0, 70};
    tv[6] = '{-3, 5, 0, 7, -1, 6, 9, 'h5555, 3, 320, 9};
    tv[7] = '{64, 1, 70, 2, 100, 3, 1, 'h7777, 0, 0, 2};

    bus.frame_start = 1'b0; bus.tri_valid = 1'b0;
    bus.tri_last = 1'b0; bus.tri_data = '0;
    reset_counts();
    #1;
    chk("rst_ctrl_zero", {bus.fb_rd_en, bus.fb_wr_en, bus.busy,
        bus.tri_ready, bus.frame_done, bus.pc_valid}, 0);
    chk("rst_tri_zero", bus.pc_triangle == 128'd0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", bus.busy, 0);
    chk("idle_no_ready", bus.tri_ready, 0);

    for (int i = 0; i < 8; i++) begin
      t = mk(tv[i].color, tv[i].x1, tv[i].y1, tv[i].x2, tv[i].y2,
             tv[i].x3, tv[i].y3, tv[i].depth);
      start_frame();
      ref_tri(tv[i].x1, tv[i].y1, tv[i].x2, tv[i].y2,
              tv[i].x3, tv[i].y3, t, n);
      send_tri(t, 1'b1, i % 3, hs);
      wait_done(dc);
      chk($sformatf("vec%0d_reads", i), rd_cnt, tv[i].n);
      chk($sformatf("vec%0d_rd_order", i), rd_bad, 0);
      chk($sformatf("vec%0d_rd_left", i), exp_rd.size(), 0);
      chk($sformatf("vec%0d_writes", i), wr_cnt, tv[i].n);
      chk($sformatf("vec%0d_wr_oob", i), wr_oob, 0);
      chk($sformatf("vec%0d_done_lat", i), dc - hs, tv[i].done_off);
      chk($sformatf("vec%0d_tri_held", i), bus.pc_triangle == t, 1);
      if (tv[i].n > 0) begin
        chk($sformatf("vec%0d_first_addr", i), rd_first, tv[i].first);
        chk($sformatf("vec%0d_last_rd", i), rd_last_cyc - hs, tv[i].n + 1);
      end
      chk_fb($sformatf("vec%0d_fb", i));
    end

    start_frame();
    t = mk('h1111, 3, 3, 7, 3, 5, 7, 200);
    tb2 = mk('h2222, 5, 5, 6, 5, 5, 6, 50);
    ref_tri(3, 3, 7, 3, 5, 7, t, n);
    ref_tri(5, 5, 6, 5, 5, 6, tb2, n);
    send_tri(t, 1'b0, 0, hs);
    bus.frame_start = 1'b1;
    @(negedge clk); bus.frame_start = 1'b0;
    send_tri(tb2, 1'b1, 0, hs2);
    wait_done(dc);
    chk("ovl_ready_gap", hs2 - hs, 25 + 4 + RL);
    chk("ovl_reads_of_pixel", rdova, 2);
    chk("ovl_raw_order", rdova2_cyc > wrova_cyc && wrova_cyc >= 0, 1);
    chk("ovl_final_word", fb[OVA], 32'h2222_0032);
    chk("ovl_rd_order", rd_bad, 0);
    chk_fb("ovl_fb");

    for (int f = 0; f < 3; f++) begin
      start_frame();
      ntri = 1 + int'($urandom_range(0, 4));
      tot = 0;
      for (int k = 0; k < ntri; k++) begin
        c[0] = int'($urandom_range(0, W + 20)) - 10;
        c[1] = int'($urandom_range(0, H + 20)) - 10;
        for (int j = 0; j < 6; j++)
          if (j >= 2 || k >= 0)
            c[j] = c[j % 2] + int'($urandom_range(0, 24)) - 12;
        t = mk(int'($urandom_range(0, 65535)), c[0], c[1], c[2], c[3],
               c[4], c[5], int'($urandom_range(0, 65535)));
        ref_tri(c[0], c[1], c[2], c[3], c[4], c[5], t, n);
        tot += n;
        send_tri(t, k == ntri - 1, int'($urandom_range(0, 3)), hs);
      end
      wait_done(dc);
      chk($sformatf("rnd%0d_reads", f), rd_cnt, tot);
      chk($sformatf("rnd%0d_rd_order", f), rd_bad, 0);
      chk($sformatf("rnd%0d_rd_left", f), exp_rd.size(), 0);
      chk($sformatf("rnd%0d_writes", f), wr_cnt, tot);
      chk($sformatf("rnd%0d_wr_oob", f), wr_oob, 0);
      chk_fb($sformatf("rnd%0d_fb", f));
    end

    start_frame();
    t = mk('h07E0, -50, -20, 400, -20, 100, 300, 300);
    send_tri(t, 1'b1, 0, hs);
    repeat (100) @(negedge clk);
    chk("pre_rst_scanning", bus.fb_rd_en, 1);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl_zero", {bus.fb_rd_en, bus.fb_wr_en, bus.busy,
        bus.tri_ready, bus.frame_done, bus.pc_valid}, 0);
    chk("midrst_data_zero", {bus.fb_rd_addr, bus.fb_wr_addr,
        bus.pc_xcoord, bus.pc_ycoord}, 0);
    chk("midrst_wdata_zero", bus.fb_wr_data | bus.pc_pixel_data, 0);
    chk("midrst_tri_zero", bus.pc_triangle == 128'd0, 1);
    reset_counts();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_writes", wr_cnt, 0);
    chk("post_rst_reads", rd_cnt, 0);
    chk("post_rst_busy", bus.busy, 0);
    start_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
